// File: rtl/uart_hex_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_assembler
// Brief    : Decodes ASCII hex characters from a UART receiver and pairs the
//            nibbles (high first) into bytes. It also flags malformed input and
//            discards a stale half-byte after a timeout.
// Revision : 1.0
// ============================================================================
module uart_hex_assembler #(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int TO_WIDTH       = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_complete,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       hex_error,
  output logic       timeout,
  output logic       nibble_pending
);

  typedef enum logic [0:0] {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_t;

  localparam logic [TO_WIDTH-1:0] c_to_last = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_nx;
  logic [3:0]          r_hi_nib, w_hi_nib_nx;
  logic [TO_WIDTH-1:0] r_timer, w_timer_nx;
  logic [7:0]          r_byte_out, w_byte_out_nx;
  logic                r_byte_valid, w_byte_valid_nx;
  logic                r_hex_error, w_hex_error_nx;
  logic                r_timeout, w_timeout_nx;
  logic                r_rx_complete_d;
  logic                r_armed;

  logic                w_new_char;
  logic                w_is_hex;
  logic                w_is_term;
  logic [3:0]          w_val;

  // r_armed masks the first cycle after reset, so a level that is already high is not taken as a new edge
  assign w_new_char = rx_complete & ~r_rx_complete_d & r_armed;

  always_comb begin
    w_is_hex  = 1'b0;
    w_is_term = 1'b0;
    w_val     = 4'h0;
    case (rx_byte) inside
      [8'h30:8'h39]: begin
        w_is_hex = 1'b1;
        w_val    = rx_byte[3:0];
      end
      [8'h41:8'h46], [8'h61:8'h66]: begin
        w_is_hex = 1'b1;
        w_val    = rx_byte[3:0] + 4'd9;
      end
      8'h0D, 8'h0A: w_is_term = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx      = r_state;
    w_hi_nib_nx     = r_hi_nib;
    w_timer_nx      = r_timer;
    w_byte_out_nx   = r_byte_out;
    w_byte_valid_nx = 1'b0;
    w_hex_error_nx  = 1'b0;
    w_timeout_nx    = 1'b0;
    case (r_state)
      S_HI: begin
        if (w_new_char) begin
          if (w_is_hex) begin
            w_hi_nib_nx = w_val;
            w_state_nx  = S_LO;
            w_timer_nx  = '0;
          end else if (!w_is_term) begin
            w_hex_error_nx = 1'b1;
          end
        end
      end
      S_LO: begin
        if (w_new_char) begin
          // Any character ends the pending byte, so the timer has nothing to do here
          w_state_nx = S_HI;
          w_timer_nx = '0;
          if (w_is_hex) begin
            w_byte_out_nx   = {r_hi_nib, w_val};
            w_byte_valid_nx = 1'b1;
          end else if (!w_is_term) begin
            w_hex_error_nx = 1'b1;
          end
        end else if (r_timer == c_to_last) begin
          w_timeout_nx = 1'b1;
          w_state_nx   = S_HI;
          w_timer_nx   = '0;
        end else if (r_timer != '1) begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      default: w_state_nx = S_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_HI;
      r_hi_nib        <= 4'h0;
      r_timer         <= '0;
      r_byte_out      <= 8'h00;
      r_byte_valid    <= 1'b0;
      r_hex_error     <= 1'b0;
      r_timeout       <= 1'b0;
      r_rx_complete_d <= 1'b0;
      r_armed         <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_hi_nib        <= w_hi_nib_nx;
      r_timer         <= w_timer_nx;
      r_byte_out      <= w_byte_out_nx;
      r_byte_valid    <= w_byte_valid_nx;
      r_hex_error     <= w_hex_error_nx;
      r_timeout       <= w_timeout_nx;
      r_rx_complete_d <= rx_complete;
      r_armed         <= 1'b1;
    end
  end

  assign byte_out       = r_byte_out;
  assign byte_valid     = r_byte_valid;
  assign hex_error      = r_hex_error;
  assign timeout        = r_timeout;
  assign nibble_pending = (r_state == S_LO);

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_hex_assembler
// Brief    : Event-level reference model versus the hex assembler, using
//            directed plus random character streams.
// Revision : 1.0
// ============================================================================
module tb_uart_hex_assembler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_complete;
  logic [7:0] byte_out;
  logic       byte_valid, hex_error, timeout, nibble_pending;

  uart_hex_assembler #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_complete(rx_complete),
    .byte_out(byte_out), .byte_valid(byte_valid), .hex_error(hex_error),
    .timeout(timeout), .nibble_pending(nibble_pending)
  );

  always #5 clk = ~clk;

  typedef struct {int t; int k; int d;} ev_t;  // k: 1=byte 2=error 3=timeout
  ev_t exp_q[$];
  ev_t act_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  bit         m_pend = 1'b0;
  int         m_hi   = 0;
  int         m_entry = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // 0 = hex digit, 1 = CR/LF terminator, 2 = anything else
  function automatic int kind_of(input logic [7:0] c);
    if ((c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f")) return 0;
    if (c == 8'h0D || c == 8'h0A) return 1;
    return 2;
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return int'(c) - int'("a") + 10;
  endfunction

  function automatic ev_t mk(input int t, input int k, input int d);
    ev_t e;
    e.t = t; e.k = k; e.d = d;
    return e;
  endfunction

  // Model sees each character at the clock edge that samples its rising flag
  task automatic model_char(input logic [7:0] c, input int t);
    int k;
    if (m_pend && t > m_entry + TO) begin
      exp_q.push_back(mk(m_entry + TO, 3, 0));
      m_pend = 1'b0;
    end
    k = kind_of(c);
    if (m_pend) begin
      if (k == 0) exp_q.push_back(mk(t, 1, m_hi * 16 + hexval(c)));
      else if (k == 2) exp_q.push_back(mk(t, 2, 0));
      m_pend = 1'b0;
    end else begin
      if (k == 0) begin
        m_pend = 1'b1; m_hi = hexval(c); m_entry = t;
      end else if (k == 2) begin
        exp_q.push_back(mk(t, 2, 0));
      end
    end
  endtask

  task automatic send(input logic [7:0] c, input int hold, input int gap);
    @(negedge clk);
    rx_byte = c;
    rx_complete = 1'b1;
    if (mon_en) model_char(c, cyc + 1);
    repeat (hold) @(negedge clk);
    rx_complete = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("exclusive_pulses", 32'($countones({byte_valid, hex_error, timeout}) > 1), 32'd0);
      if (byte_valid) act_q.push_back(mk(cyc, 1, int'(byte_out)));
      if (hex_error)  act_q.push_back(mk(cyc, 2, 0));
      if (timeout)    act_q.push_back(mk(cyc, 3, 0));
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_byte_out"}, 32'(byte_out), 32'h00);
    chk({tag, "_pulses"}, 32'({byte_valid, hex_error, timeout}), 32'd0);
    chk({tag, "_pending"}, 32'(nibble_pending), 32'd0);
  endtask

  initial begin
    string hexs;
    int    r, n;
    logic [7:0] c;
    hexs = "0123456789ABCDEFabcdef";
    reset = 1'b1; rx_complete = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");

    // A level already high when reset releases is not a character
    rx_byte = "5"; rx_complete = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle_outputs("level_at_reset");
    rx_complete = 1'b0;
    repeat (2) @(negedge clk);

    // A full byte, then reset while a high nibble is pending
    send("8", 1, 1); send("3", 1, 2);
    chk("direct_byte", 32'(byte_out), 32'h83);
    send("8", 1, 2);
    chk("direct_pending", 32'(nibble_pending), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk_idle_outputs("reset_mid_byte");
    repeat (3) @(negedge clk);
    chk_idle_outputs("after_reset_quiet");

    mon_en = 1'b1;
    m_pend = 1'b0;
    send("4", 1, 2); send("f", 1, 3);
    send("A", 1, 1); send("0", 1, 1); send("a", 2, 1); send("0", 1, 4);
    send("3", 1, 1); send("G", 1, 1); send("1", 1, 1); send("2", 1, 3);
    send("7", 1, 20); send("5", 1, 1); send("5", 1, 2);
    send("9", 10, 2); send(8'h0D, 1, 3);
    send("C", 1, 15); send("B", 1, 3);
    send("E", 1, 16); send("1", 1, 3);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 7) c = hexs[$urandom_range(0, 21)];
      else if (r == 8) c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      else begin
        c = 8'($urandom_range(0, 255));
        while (kind_of(c) != 2) c = 8'($urandom_range(0, 255));
      end
      r = $urandom_range(0, 9);
      n = (r < 7) ? $urandom_range(1, 3) : (r < 9) ? $urandom_range(4, 13) : $urandom_range(14, 19);
      send(c, $urandom_range(1, 4), n);
    end

    repeat (40) @(negedge clk);
    if (m_pend && cyc >= m_entry + TO) begin
      exp_q.push_back(mk(m_entry + TO, 3, 0));
      m_pend = 1'b0;
    end
    mon_en = 1'b0;

    chk("event_count", 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("ev%0d_kind", i), 32'(act_q[i].k), 32'(exp_q[i].k));
      chk($sformatf("ev%0d_cycle", i), 32'(act_q[i].t), 32'(exp_q[i].t));
      chk($sformatf("ev%0d_data", i), 32'(act_q[i].d), 32'(exp_q[i].d));
    end
    chk("final_pending", 32'(nibble_pending), 32'(m_pend));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
